// File: rtl/aximm_over_stream_server_p.sv
// AXI-MM-over-stream server: runs each AXI-Stream request packet as one AXI4-Lite read/write
// and returns one tagged response beat. Define AMOSS_ERR_RSP_EN to answer unknown types with ERROR_RSP.
module aximm_over_stream_server_p #(
  parameter int unsigned AXIS_DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AXIS_DATA_WIDTH-1:0] AXIS_RX_TDATA,
  input  logic                       AXIS_RX_TVALID,
  input  logic                       AXIS_RX_TLAST,
  output logic                       AXIS_RX_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                       AXIS_TX_TVALID,
  output logic                       AXIS_TX_TLAST,
  input  logic                       AXIS_TX_TREADY,
  output logic [ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic                       M_AXI_AWVALID,
  output logic [2:0]                 M_AXI_AWPROT,
  input  logic                       M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                       M_AXI_WVALID,
  input  logic                       M_AXI_WREADY,
  input  logic [1:0]                 M_AXI_BRESP,
  input  logic                       M_AXI_BVALID,
  output logic                       M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic                       M_AXI_ARVALID,
  output logic [2:0]                 M_AXI_ARPROT,
  input  logic                       M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY,
  output logic [CNT_WIDTH-1:0]       req_count,
  output logic [CNT_WIDTH-1:0]       err_count
);
  localparam int unsigned DW      = DATA_WIDTH / 32;
  localparam int unsigned SW      = DATA_WIDTH / 8;
  localparam int unsigned DATA_LO = 96;
  localparam int unsigned RSP_LO  = 32 * (3 + DW);

  localparam logic [7:0] T_READ_REQ  = 8'd1;
  localparam logic [7:0] T_WRITE_REQ = 8'd2;
  localparam logic [7:0] T_READ_RSP  = 8'd3;
  localparam logic [7:0] T_WRITE_RSP = 8'd4;
`ifdef AMOSS_ERR_RSP_EN
  localparam logic [7:0] T_ERROR_RSP = 8'd5;
`endif

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_DRAIN, S_WR_AW_W, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_ERR, S_SEND
  } state_t;

  state_t                     r_state;
  logic                       r_rx_tready;
  logic [AXIS_DATA_WIDTH-1:0] r_tx_tdata;
  logic                       r_tx_tvalid;
  logic                       r_tx_tlast;
  logic                       r_awvalid;
  logic                       r_wvalid;
  logic                       r_bready;
  logic                       r_arvalid;
  logic                       r_rready;
  logic [7:0]                 r_type;
  logic [15:0]                r_tag;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [SW-1:0]              r_wstrb;
  logic [CNT_WIDTH-1:0]       r_req_count;
  logic [CNT_WIDTH-1:0]       r_err_count;

  logic [7:0]            w_rx_type;
  logic [15:0]           w_rx_tag;
  logic [ADDR_WIDTH-1:0] w_rx_addr;
  logic [DATA_WIDTH-1:0] w_rx_wdata;
  logic [SW-1:0]         w_rx_strb;
  logic                  w_rx_hs;
  logic                  w_dispatch;
  logic [7:0]            w_disp_type;
  logic                  w_unused;

  assign w_rx_type  = AXIS_RX_TDATA[7:0];
  assign w_rx_tag   = AXIS_RX_TDATA[31:16];
  assign w_rx_addr  = AXIS_RX_TDATA[32 +: ADDR_WIDTH];
  assign w_rx_wdata = AXIS_RX_TDATA[DATA_LO +: DATA_WIDTH];
  assign w_rx_strb  = AXIS_RX_TDATA[RSP_LO +: SW];
  assign w_rx_hs    = AXIS_RX_TVALID & r_rx_tready;
  // The last beat of a packet launches the request held from its first beat
  assign w_dispatch  = w_rx_hs & AXIS_RX_TLAST & ((r_state == S_IDLE) | (r_state == S_DRAIN));
  assign w_disp_type = (r_state == S_IDLE) ? w_rx_type : r_type;
  assign w_unused    = ^{AXIS_RX_TDATA[15:8], AXIS_RX_TDATA[95:32],
                         AXIS_RX_TDATA[AXIS_DATA_WIDTH-1:RSP_LO+SW]};

  function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [AXIS_DATA_WIDTH-1:0] f_rsp(input logic [7:0] t, input logic [15:0] tag,
      input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d, input logic [1:0] resp);
    logic [AXIS_DATA_WIDTH-1:0] v;
    v                       = '0;
    v[7:0]                  = t;
    v[31:16]                = tag;
    v[32 +: ADDR_WIDTH]     = a;
    v[DATA_LO +: DATA_WIDTH] = d;
    v[RSP_LO +: 2]          = resp;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_rx_tready <= 1'b0;
      r_tx_tdata  <= '0;
      r_tx_tvalid <= 1'b0;
      r_tx_tlast  <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_type      <= '0;
      r_tag       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_req_count <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_rx_tready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_IDLE: if (w_rx_hs) begin
          r_req_count <= f_sat_inc(r_req_count);
          r_type      <= w_rx_type;
          r_tag       <= w_rx_tag;
          r_addr      <= w_rx_addr;
          r_wdata     <= w_rx_wdata;
          r_wstrb     <= (w_rx_strb == '0) ? '1 : w_rx_strb;
          if (!AXIS_RX_TLAST) r_state <= S_DRAIN;
        end
        S_DRAIN: ;
        S_WR_AW_W: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: if (M_AXI_BVALID) begin
          r_bready    <= 1'b0;
          r_tx_tdata  <= f_rsp(T_WRITE_RSP, r_tag, r_addr, r_wdata, M_AXI_BRESP);
          r_tx_tvalid <= 1'b1;
          r_tx_tlast  <= 1'b1;
          if (M_AXI_BRESP != 2'b00) r_err_count <= f_sat_inc(r_err_count);
          r_state     <= S_SEND;
        end
        S_RD_ADDR: if (M_AXI_ARREADY) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_RD_DATA;
        end
        S_RD_DATA: if (M_AXI_RVALID) begin
          r_rready    <= 1'b0;
          r_tx_tdata  <= f_rsp(T_READ_RSP, r_tag, r_addr, M_AXI_RDATA, M_AXI_RRESP);
          r_tx_tvalid <= 1'b1;
          r_tx_tlast  <= 1'b1;
          if (M_AXI_RRESP != 2'b00) r_err_count <= f_sat_inc(r_err_count);
          r_state     <= S_SEND;
        end
        S_ERR: begin
          r_err_count <= f_sat_inc(r_err_count);
`ifdef AMOSS_ERR_RSP_EN
          r_tx_tdata  <= f_rsp(T_ERROR_RSP, r_tag, r_addr, '0, 2'b10);
          r_tx_tvalid <= 1'b1;
          r_tx_tlast  <= 1'b1;
          r_state     <= S_SEND;
`else
          r_rx_tready <= 1'b1;
          r_state     <= S_IDLE;
`endif
        end
        S_SEND: if (AXIS_TX_TREADY) begin
          r_tx_tvalid <= 1'b0;
          r_tx_tlast  <= 1'b0;
          r_rx_tready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase

      if (w_dispatch) begin
        r_rx_tready <= 1'b0;
        case (w_disp_type)
          T_READ_REQ: begin
            r_arvalid <= 1'b1;
            r_state   <= S_RD_ADDR;
          end
          T_WRITE_REQ: begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR_AW_W;
          end
          default: r_state <= S_ERR;
        endcase
      end
    end
  end

  assign AXIS_RX_TREADY = r_rx_tready;
  assign AXIS_TX_TDATA  = r_tx_tdata;
  assign AXIS_TX_TVALID = r_tx_tvalid;
  assign AXIS_TX_TLAST  = r_tx_tlast;
  assign M_AXI_AWADDR   = r_addr;
  assign M_AXI_AWVALID  = r_awvalid;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_WDATA    = r_wdata;
  assign M_AXI_WSTRB    = r_wstrb;
  assign M_AXI_WVALID   = r_wvalid;
  assign M_AXI_BREADY   = r_bready;
  assign M_AXI_ARADDR   = r_addr;
  assign M_AXI_ARVALID  = r_arvalid;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_RREADY   = r_rready;
  assign req_count      = r_req_count;
  assign err_count      = r_err_count;

endmodule
